pxs_demux2: RTL and testbench

Frame-synchronous 1:2 demultiplexer for 26-bit pixel streams. It routes one input stream to one of two output streams and changes the route only at a frame start. The port not selected is driven with the idle word. It sits downstream of a stream source and fans the stream out to two processing branches, which a stream mux later recombines.

---
 rtl/pxs_demux2.sv | 83 ++++++++
 tb/tb_pxs_demux2.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pxs_demux2.sv
// Frame-synchronous 1:2 demultiplexer for 26-bit {vsync, hsync, RGB} pixel streams.
// Define PXS_DEMUX_FRAMESYNC_EN for frame-synchronous routing; otherwise control routes every cycle.
module pxs_demux2 (
  input  logic        px_clk,
  input  logic        rst,
  input  logic [25:0] RGBStr_i,
  input  logic        control,
  output logic [25:0] RGBStr1_o,
  output logic [25:0] RGBStr2_o,
  output logic        sel_o,
  output logic        pending_o,
  output logic        locked_o
);

  localparam logic [25:0] IDLE_WORD = 26'h0;

`ifdef PXS_DEMUX_FRAMESYNC_EN

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_R1   = 2'd1,
    S_R2   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   vs_d;
  logic   frame_start;

  // A vsync already high when reset releases is not a frame start, hence vs_d resets to 1.
  assign frame_start = RGBStr_i[25] & ~vs_d;

  // The route decided in this cycle also applies to this cycle's word, so outputs use state_nxt.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    state_nxt = state;
    if (frame_start) state_nxt = control ? S_R2 : S_R1;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous active-high.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT;
      vs_d      <= 1'b1;
      RGBStr1_o <= IDLE_WORD;
      RGBStr2_o <= IDLE_WORD;
      sel_o     <= 1'b0;
      pending_o <= 1'b0;
      locked_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      vs_d      <= RGBStr_i[25];
      RGBStr1_o <= (state_nxt == S_R1) ? RGBStr_i : IDLE_WORD;
      RGBStr2_o <= (state_nxt == S_R2) ? RGBStr_i : IDLE_WORD;
      sel_o     <= (state_nxt == S_R2);
      locked_o  <= (state_nxt != S_WAIT);
      // Compared against the route taking effect at this edge, so a completed switch shows no pending.
      pending_o <= (state_nxt != S_WAIT) && (control != (state_nxt == S_R2));
    end
  end

`else

  assign pending_o = 1'b0;

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous active-high.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      RGBStr1_o <= IDLE_WORD;
      RGBStr2_o <= IDLE_WORD;
      sel_o     <= 1'b0;
      locked_o  <= 1'b0;
    end else begin
      RGBStr1_o <= control ? IDLE_WORD : RGBStr_i;
      RGBStr2_o <= control ? RGBStr_i : IDLE_WORD;
      sel_o     <= control;
      locked_o  <= 1'b1;
    end
  end

`endif

endmodule

// File: tb/tb_pxs_demux2.sv
// Self-checking bench for pxs_demux2: directed test-plan steps plus randomized frames,
// compared against a frame-level reference model of the routing rules.
module tb_pxs_demux2;

  logic        px_clk = 1'b0;
  logic        rst;
  logic [25:0] RGBStr_i;
  logic        control;
  logic [25:0] RGBStr1_o;
  logic [25:0] RGBStr2_o;
  logic        sel_o;
  logic        pending_o;
  logic        locked_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: which port owns the stream, whether a frame start has been seen.
  logic        m_prev_vs;
  logic        m_route;
  logic        m_locked;
  logic [25:0] m_word;
  logic        m_ctrl;

  pxs_demux2 dut (
    .px_clk    (px_clk),
    .rst       (rst),
    .RGBStr_i  (RGBStr_i),
    .control   (control),
    .RGBStr1_o (RGBStr1_o),
    .RGBStr2_o (RGBStr2_o),
    .sel_o     (sel_o),
    .pending_o (pending_o),
    .locked_o  (locked_o)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_vs = 1'b1;
    m_route   = 1'b0;
    m_locked  = 1'b0;
    m_word    = 26'h0;
    m_ctrl    = 1'b0;
  endtask

  task automatic model_step(input logic [25:0] w, input logic c);
    m_word = w;
    m_ctrl = c;
`ifdef PXS_DEMUX_FRAMESYNC_EN
    if (w[25] && !m_prev_vs) begin
      m_locked = 1'b1;
      m_route  = c;
    end
    m_prev_vs = w[25];
`else
    m_locked = 1'b1;
    m_route  = c;
`endif
  endtask

  task automatic check_all(input string tag);
    logic exp_pend;
`ifdef PXS_DEMUX_FRAMESYNC_EN
    exp_pend = m_locked && (m_ctrl != m_route);
`else
    exp_pend = 1'b0;
`endif
    check({tag, ".out1"},    RGBStr1_o, (m_locked && !m_route) ? m_word : 26'h0);
    check({tag, ".out2"},    RGBStr2_o, (m_locked &&  m_route) ? m_word : 26'h0);
    check({tag, ".sel"},     {25'h0, sel_o},     {25'h0, m_locked & m_route});
    check({tag, ".pending"}, {25'h0, pending_o}, {25'h0, exp_pend});
    check({tag, ".locked"},  {25'h0, locked_o},  {25'h0, m_locked});
  endtask

  // Drive one word, let one edge pass, then compare away from the edge.
  task automatic step(input string tag, input logic [25:0] w, input logic c);
    RGBStr_i = w;
    control  = c;
    @(posedge px_clk);
    #1;
    model_step(w, c);
    check_all(tag);
  endtask

  function automatic logic [25:0] word(input logic vs, input logic hs);
    logic [31:0] r;
    r = $urandom();
    return {vs, hs, r[23:0]};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".out1"}, RGBStr1_o, 26'h0);
    check({tag, ".out2"}, RGBStr2_o, 26'h0);
    check({tag, ".sel"},  {25'h0, sel_o},     26'h0);
    check({tag, ".pend"}, {25'h0, pending_o}, 26'h0);
`ifdef PXS_DEMUX_FRAMESYNC_EN
    check({tag, ".lock"}, {25'h0, locked_o},  26'h0);
`endif
  endtask

  initial begin
    logic c;
    int   len;

    // Reset with vsync held high and control=0.
    rst      = 1'b1;
    RGBStr_i = {2'b10, 24'h0};
    control  = 1'b0;
    model_reset();
    repeat (2) @(posedge px_clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 3; i++) step("vs_held", word(1'b1, 1'b0), 1'b0);
    step("vs_low", word(1'b0, 1'b0), 1'b0);
    step("vs_low", word(1'b0, 1'b1), 1'b0);
    step("first_fs", word(1'b1, 1'b0), 1'b0);
    check("first_fs.out1_vs", {25'h0, RGBStr1_o[25]}, 26'h1);
    check("first_fs.locked",  {25'h0, locked_o},      26'h1);

    // Pixel passthrough on port 1.
    step("vs_low", word(1'b0, 1'b0), 1'b0);
    step("pix123456", {2'b00, 24'h123456}, 1'b0);
    check("pix123456.rgb", {2'b00, RGBStr1_o[23:0]}, {2'b00, 24'h123456});
    check("pix123456.out2", RGBStr2_o, 26'h0);

    // Control raised mid-frame; switch happens at the next frame start.
    for (int i = 0; i < 4; i++) step("req_r2", word(1'b0, i[0]), 1'b1);
    step("switch_fs", word(1'b1, 1'b0), 1'b1);
    step("in_r2", word(1'b1, 1'b0), 1'b1);
    for (int i = 0; i < 3; i++) step("in_r2", word(1'b0, 1'b0), 1'b1);

    // Back to R1, then a 0->1->0 toggle between frame starts.
    step("back_r1", word(1'b1, 1'b0), 1'b0);
    step("back_r1", word(1'b0, 1'b0), 1'b0);
    step("toggle0", word(1'b0, 1'b0), 1'b0);
    step("toggle1", word(1'b0, 1'b1), 1'b1);
    step("toggle1", word(1'b0, 1'b0), 1'b1);
    step("toggle0", word(1'b0, 1'b0), 1'b0);
    step("toggle0", word(1'b0, 1'b0), 1'b0);

    // Into R2, then reset pulsed mid-frame.
    step("to_r2", word(1'b1, 1'b0), 1'b1);
    for (int i = 0; i < 3; i++) step("r2_frame", word(1'b0, 1'b0), 1'b1);
    rst = 1'b1;
    #1;
    check_idle("mid_rst");
    model_reset();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst", word(1'b0, 1'b0), 1'b1);
    step("post_rst_fs", word(1'b1, 1'b0), 1'b1);
    step("post_rst", word(1'b0, 1'b0), 1'b1);

    // Randomized frames with occasional control changes.
    c = 1'b0;
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(3, 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3, 0) == 0) c = ~c;
        step("rnd_vs", word(1'b1, 1'b0), c);
      end
      len = $urandom_range(30, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(7, 0) == 0) c = ~c;
        step("rnd_px", word(1'b0, ($urandom_range(4, 0) == 0)), c);
      end
    end

    // Control toggled every cycle, including across frame starts.
    c = 1'b0;
    for (int i = 0; i < 24; i++) begin
      c = ~c;
      step("toggle_each", word((i % 8) < 2, 1'b0), c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
